// File: rtl/sid_multi_pkg.sv
// Shared state codes, register map, pan codes and arithmetic helpers for the
// multi-SID control block.
package sid_multi_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_TBL  = 2'd1;
  localparam state_t ST_FILT = 2'd2;
  localparam state_t ST_MIX  = 2'd3;

  localparam int NUM_REGS = 25;

  localparam logic [4:0] ADDR_V1_FREQ_LO = 5'h00, ADDR_V1_FREQ_HI = 5'h01;
  localparam logic [4:0] ADDR_V1_PW_LO   = 5'h02, ADDR_V1_PW_HI   = 5'h03;
  localparam logic [4:0] ADDR_V1_CTRL    = 5'h04, ADDR_V1_AD      = 5'h05;
  localparam logic [4:0] ADDR_V1_SR      = 5'h06, ADDR_V2_FREQ_LO = 5'h07;
  localparam logic [4:0] ADDR_V2_FREQ_HI = 5'h08, ADDR_V2_PW_LO   = 5'h09;
  localparam logic [4:0] ADDR_V2_PW_HI   = 5'h0A, ADDR_V2_CTRL    = 5'h0B;
  localparam logic [4:0] ADDR_V2_AD      = 5'h0C, ADDR_V2_SR      = 5'h0D;
  localparam logic [4:0] ADDR_V3_FREQ_LO = 5'h0E, ADDR_V3_FREQ_HI = 5'h0F;
  localparam logic [4:0] ADDR_V3_PW_LO   = 5'h10, ADDR_V3_PW_HI   = 5'h11;
  localparam logic [4:0] ADDR_V3_CTRL    = 5'h12, ADDR_V3_AD      = 5'h13;
  localparam logic [4:0] ADDR_V3_SR      = 5'h14, ADDR_FC_LO      = 5'h15;
  localparam logic [4:0] ADDR_FC_HI      = 5'h16, ADDR_RES_FILT   = 5'h17;
  localparam logic [4:0] ADDR_MODE_VOL   = 5'h18, ADDR_POT_X      = 5'h19;
  localparam logic [4:0] ADDR_POT_Y      = 5'h1A, ADDR_OSC3       = 5'h1B;
  localparam logic [4:0] ADDR_ENV3       = 5'h1C;

  localparam logic [1:0] PAN_MUTE  = 2'b00;
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;
  localparam logic [1:0] PAN_BOTH  = 2'b11;

  localparam logic [7:0] MASK_PW_HI = 8'h0F;
  localparam logic [7:0] MASK_FC_LO = 8'h07;
  localparam logic [7:0] MASK_FULL  = 8'hFF;

  function automatic logic [7:0] reg_mask(input logic [4:0] a);
    case (a)
      ADDR_V1_PW_HI, ADDR_V2_PW_HI, ADDR_V3_PW_HI: reg_mask = MASK_PW_HI;
      ADDR_FC_LO:                                  reg_mask = MASK_FC_LO;
      default:                                     reg_mask = MASK_FULL;
    endcase
  endfunction

  // Adds two wide operands and clamps the result to an aw-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int aw);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (aw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (aw - 1));
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// Per-chip read-bus latch: holds the last written byte and fades to zero after
// DECAY_TICKS ce_1m ticks without a write.
module sid_bus_latch #(
  parameter int DECAY_TICKS = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] latch
);

  localparam int CW = $clog2(DECAY_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DECAY_TICKS);

  logic [CW-1:0] decay_cnt;

  // A write restarts the decay; the tick that reaches the limit clears the byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch     <= 8'h00;
      decay_cnt <= '0;
    end else if (wr) begin
      latch     <= wdata;
      decay_cnt <= '0;
    end else if (ce_1m && (decay_cnt != CNT_MAX)) begin
      decay_cnt <= decay_cnt + CW'(1);
      if (decay_cnt == (CNT_MAX - CW'(1))) begin
        latch <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/sid_multi_ctrl.sv
// Multi-SID top-level control: register banks, bus readback, table/filter
// time-slot scheduler and saturating stereo mix.
module sid_multi_ctrl
  import sid_multi_pkg::*;
#(
  parameter int NUM_SID     = 2,
  parameter int TBL_LAT     = 1,
  parameter int FILT_CYCLES = 8,
  parameter int DECAY_TICKS = 2000,
  parameter int AW          = 18
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce_1m,
  input  logic [NUM_SID-1:0]        cs,
  input  logic                      we,
  input  logic [4:0]                addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [8*NUM_SID-1:0]      pot_x,
  input  logic [8*NUM_SID-1:0]      pot_y,
  input  logic [8*NUM_SID-1:0]      osc3,
  input  logic [8*NUM_SID-1:0]      env3,
  output logic [200*NUM_SID-1:0]    regs,
  output logic                      tbl_req,
  output logic [4:0]                tbl_idx,
  output logic                      tbl_rsp_valid,
  output logic [4:0]                tbl_rsp_idx,
  output logic [2:0]                filt_sel,
  output logic                      filt_start,
  input  logic signed [AW-1:0]      filt_audio,
  input  logic [2*NUM_SID-1:0]      pan,
  output logic [AW*NUM_SID-1:0]     audio_chip,
  output logic signed [AW-1:0]      audio_l,
  output logic signed [AW-1:0]      audio_r,
  output logic                      overrun
);

  localparam int SW   = (NUM_SID > 1) ? $clog2(NUM_SID) : 1;
  localparam int PW   = $clog2(TBL_LAT + 1);
  localparam int FW   = $clog2(FILT_CYCLES);
  localparam int SUMW = AW + 3;
  localparam logic [4:0] LAST_V = 5'(3 * NUM_SID - 1);

  logic [7:0] reg_file [NUM_SID][NUM_REGS];
  logic [7:0] latch    [NUM_SID];
  logic [7:0] pot_x_a  [NUM_SID];
  logic [7:0] pot_y_a  [NUM_SID];
  logic [7:0] osc3_a   [NUM_SID];
  logic [7:0] env3_a   [NUM_SID];
  logic       pan_l    [NUM_SID];
  logic       pan_r    [NUM_SID];
  logic signed [AW-1:0] ach [NUM_SID];

  for (genvar g = 0; g < NUM_SID; g++) begin : g_chip
    assign pot_x_a[g] = pot_x[g*8 +: 8];
    assign pot_y_a[g] = pot_y[g*8 +: 8];
    assign osc3_a[g]  = osc3[g*8 +: 8];
    assign env3_a[g]  = env3[g*8 +: 8];
    assign pan_l[g]   = pan[2*g];
    assign pan_r[g]   = pan[2*g+1];
    assign audio_chip[g*AW +: AW] = ach[g];
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign regs[(g*NUM_REGS+r)*8 +: 8] = reg_file[g][r];
    end
    sid_bus_latch #(.DECAY_TICKS(DECAY_TICKS)) u_latch (
      .clk     (clk),
      .reset_n (reset_n),
      .ce_1m   (ce_1m),
      .wr      (we & cs[g]),
      .wdata   (data_in),
      .latch   (latch[g])
    );
  end

  // Register file write: every selected chip takes the masked byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_SID; c++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          reg_file[c][r] <= 8'h00;
        end
      end
    end else begin
      for (int c = 0; c < NUM_SID; c++) begin
        if (we && cs[c] && (addr < 5'(NUM_REGS))) begin
          reg_file[c][addr] <= data_in & reg_mask(addr);
        end
      end
    end
  end

  logic [SW-1:0] sel;
  logic          sel_ok;

  // Readback from the lowest selected chip; no selection floats the bus high.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    for (int c = NUM_SID - 1; c >= 0; c--) begin
      sel    = cs[c] ? SW'(c) : sel;
      sel_ok = sel_ok | cs[c];
    end
    if (!sel_ok) begin
      data_out = 8'hFF;
    end else begin
      case (addr)
        ADDR_POT_X: data_out = pot_x_a[sel];
        ADDR_POT_Y: data_out = pot_y_a[sel];
        ADDR_OSC3:  data_out = osc3_a[sel];
        ADDR_ENV3:  data_out = env3_a[sel];
        default:    data_out = latch[sel];
      endcase
    end
  end

  state_t        state, state_n;
  logic [4:0]    v, v_n;
  logic [PW-1:0] ph, ph_n;
  logic [SW-1:0] chip, chip_n;
  logic [FW-1:0] fc, fc_n;

  // Scheduler next state; a tick outside IDLE restarts the table pass.
  always_comb begin
    state_n = state;
    v_n     = v;
    ph_n    = ph;
    chip_n  = chip;
    fc_n    = fc;
    case (state)
      ST_IDLE: begin
        if (ce_1m) begin
          state_n = ST_TBL;
          v_n     = 5'd0;
          ph_n    = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_TBL: begin
        if (ph == PW'(TBL_LAT)) begin
          ph_n = '0;
          if (v == LAST_V) begin
            state_n = ST_FILT;
            chip_n  = '0;
            fc_n    = '0;
          end else begin
            v_n = v + 5'd1;
          end
        end else begin
          ph_n = ph + PW'(1);
        end
      end
      ST_FILT: begin
        if (fc == FW'(FILT_CYCLES - 1)) begin
          fc_n = '0;
          if (chip == SW'(NUM_SID - 1)) begin
            state_n = ST_MIX;
          end else begin
            chip_n = chip + SW'(1);
          end
        end else begin
          fc_n = fc + FW'(1);
        end
      end
      ST_MIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (ce_1m && (state != ST_IDLE)) begin
      state_n = ST_TBL;
      v_n     = 5'd0;
      ph_n    = '0;
    end else begin
      state_n = state_n;
    end
  end

  // Strobes are registered from the next-state so they line up with the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      v             <= 5'd0;
      ph            <= '0;
      chip          <= '0;
      fc            <= '0;
      tbl_req       <= 1'b0;
      tbl_idx       <= 5'd0;
      tbl_rsp_valid <= 1'b0;
      tbl_rsp_idx   <= 5'd0;
      filt_start    <= 1'b0;
      filt_sel      <= 3'd0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_n;
      v             <= v_n;
      ph            <= ph_n;
      chip          <= chip_n;
      fc            <= fc_n;
      tbl_req       <= (state_n == ST_TBL) && (ph_n == '0);
      tbl_idx       <= v_n;
      tbl_rsp_valid <= (state_n == ST_TBL) && (ph_n == PW'(TBL_LAT));
      tbl_rsp_idx   <= v_n;
      filt_start    <= (state_n == ST_FILT) && (fc_n == '0);
      filt_sel      <= 3'(chip_n);
      if (ce_1m && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  logic signed [SUMW-1:0] sum_l, sum_r, ext;

  // Wide pan-weighted sums; AW+3 bits cannot overflow for up to 8 chips.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    ext   = '0;
    for (int c = 0; c < NUM_SID; c++) begin
      ext   = SUMW'(ach[c]);
      sum_l = sum_l + (pan_l[c] ? ext : SUMW'(0));
      sum_r = sum_r + (pan_r[c] ? ext : SUMW'(0));
    end
  end

  // Per-chip capture at the end of its filter window and the one-cycle mix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_SID; c++) begin
        ach[c] <= '0;
      end
      audio_l <= '0;
      audio_r <= '0;
    end else begin
      if ((state == ST_FILT) && (fc == FW'(FILT_CYCLES - 1))) begin
        ach[chip] <= filt_audio;
      end
      if (state == ST_MIX) begin
        audio_l <= AW'(sat_add(32'(sum_l), 32'sd0, AW));
        audio_r <= AW'(sat_add(32'(sum_r), 32'sd0, AW));
      end
    end
  end

endmodule

// File: tb/tb_sid_multi_ctrl.sv
// Directed self-checking bench for sid_multi_ctrl (NUM_SID=2, TBL_LAT=1,
// FILT_CYCLES=8) with hand-computed expected values.
module tb_sid_multi_ctrl;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               ce_1m;
  logic [1:0]         cs;
  logic               we;
  logic [4:0]         addr;
  logic [7:0]         data_in;
  logic [7:0]         data_out;
  logic [15:0]        pot_x, pot_y, osc3, env3;
  logic [399:0]       regs;
  logic               tbl_req;
  logic [4:0]         tbl_idx;
  logic               tbl_rsp_valid;
  logic [4:0]         tbl_rsp_idx;
  logic [2:0]         filt_sel;
  logic               filt_start;
  logic signed [17:0] filt_audio;
  logic [3:0]         pan;
  logic [35:0]        audio_chip;
  logic signed [17:0] audio_l, audio_r;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  sid_multi_ctrl #(.NUM_SID(2), .TBL_LAT(1), .FILT_CYCLES(8),
                   .DECAY_TICKS(2000), .AW(18)) dut (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .cs(cs), .we(we),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3), .regs(regs),
    .tbl_req(tbl_req), .tbl_idx(tbl_idx), .tbl_rsp_valid(tbl_rsp_valid),
    .tbl_rsp_idx(tbl_rsp_idx), .filt_sel(filt_sel), .filt_start(filt_start),
    .filt_audio(filt_audio), .pan(pan), .audio_chip(audio_chip),
    .audio_l(audio_l), .audio_r(audio_r), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [4:0] a, input logic [7:0] d);
    cs = c; addr = a; data_in = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce_1m = 1'b0; cs = 2'b00; we = 1'b0; addr = 5'd0;
    data_in = 8'h00; pot_x = 16'h0; pot_y = 16'h0; osc3 = 16'h0; env3 = 16'h0;
    filt_audio = 18'sd0; pan = 4'b0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_regs", 32'(regs == 400'd0), 32'd1);
    check("rst_audio_l", 32'(audio_l), 32'd0);
    check("rst_audio_r", 32'(audio_r), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_tbl_req", 32'(tbl_req), 32'd0);
    check("rst_dout_ff", 32'(data_out), 32'hFF);

    // Register writes, masks and latch readback
    wr(2'b01, 5'h03, 8'hAB);
    check("reg0_3_mask", 32'(regs[3*8 +: 8]), 32'h0B);
    check("reg1_3_untouched", 32'(regs[28*8 +: 8]), 32'h00);
    cs = 2'b01; addr = 5'h03; #1;
    check("rd_latch_ab", 32'(data_out), 32'hAB);
    wr(2'b11, 5'h15, 8'hFF);
    check("reg0_15_mask", 32'(regs[21*8 +: 8]), 32'h07);
    check("reg1_15_mask", 32'(regs[46*8 +: 8]), 32'h07);
    wr(2'b01, 5'h04, 8'h5E);
    check("reg0_4_full", 32'(regs[4*8 +: 8]), 32'h5E);
    wr(2'b10, 5'h1D, 8'h77);
    check("reg1_18_kept", 32'(regs[49*8 +: 8]), 32'h00);
    cs = 2'b10; addr = 5'h05; #1;
    check("rd_latch_hi_addr", 32'(data_out), 32'h77);

    // Readback ports and lowest-cs priority
    osc3 = {8'h5A, 8'h11}; pot_x = {8'h22, 8'h33}; pot_y = {8'h44, 8'h55};
    env3 = {8'h66, 8'h99};
    cs = 2'b10; addr = 5'h1B; #1;
    check("rd_osc3_c1", 32'(data_out), 32'h5A);
    cs = 2'b11; #1;
    check("rd_osc3_lowest", 32'(data_out), 32'h11);
    cs = 2'b10; addr = 5'h19; #1;
    check("rd_potx_c1", 32'(data_out), 32'h22);
    cs = 2'b01; addr = 5'h1A; #1;
    check("rd_poty_c0", 32'(data_out), 32'h55);
    addr = 5'h1C; #1;
    check("rd_env3_c0", 32'(data_out), 32'h99);
    cs = 2'b00; #1;

    // Full schedule; cycle k counts edges after the one that samples ce_1m
    pan = 4'b1101; filt_audio = 18'sd100000;
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      check("sch_tbl_req", 32'(tbl_req), 32'((k % 2 == 1) && (k <= 11)));
      if ((k % 2 == 1) && (k <= 11)) check("sch_tbl_idx", 32'(tbl_idx), 32'((k - 1) / 2));
      check("sch_rsp_valid", 32'(tbl_rsp_valid), 32'((k % 2 == 0) && (k <= 12)));
      if ((k % 2 == 0) && (k <= 12)) check("sch_rsp_idx", 32'(tbl_rsp_idx), 32'((k - 2) / 2));
      check("sch_filt_start", 32'(filt_start), 32'((k == 13) || (k == 21)));
      if ((k >= 13) && (k <= 28)) check("sch_filt_sel", 32'(filt_sel), 32'(k >= 21));
      if (k == 29) check("mix_not_yet", 32'(audio_l), 32'd0);
      if (k < 30) tick();
    end
    check("mix_l_sat_hi", 32'(audio_l), 32'd131071);
    check("mix_r", 32'(audio_r), 32'd100000);
    check("chip0_audio", 32'(audio_chip[17:0]), 32'd100000);
    check("chip1_audio", 32'(audio_chip[35:18]), 32'd100000);
    check("no_overrun", 32'(overrun), 32'd0);

    // Negative saturation, left bus has no contributors
    pan = 4'b1010; filt_audio = -18'sd100000;
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    repeat (29) tick();
    check("mix_r_sat_lo", 32'(audio_r), -32'sd131072);
    check("mix_l_empty", 32'(audio_l), 32'd0);
    check("no_overrun2", 32'(overrun), 32'd0);

    // Overrun: second tick 10 cycles after the first
    pan = 4'b0101; filt_audio = -18'sd5000;
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    repeat (9) tick();
    check("ovr_before", 32'(overrun), 32'd0);
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_req", 32'(tbl_req), 32'd1);
    check("ovr_idx0", 32'(tbl_idx), 32'd0);
    for (int k = 1; k <= 30; k++) begin
      check("ovr_filt_start", 32'(filt_start), 32'((k == 13) || (k == 21)));
      if (k == 11) check("ovr_last_idx", 32'(tbl_idx), 32'd5);
      if (k == 29) check("ovr_mix_hold", 32'(audio_r), -32'sd131072);
      if (k < 30) tick();
    end
    check("ovr_mix_l", 32'(audio_l), -32'sd10000);
    check("ovr_mix_r", 32'(audio_r), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Write and tick in the same cycle both take effect
    cs = 2'b01; addr = 5'h18; data_in = 8'h9C; we = 1'b1; ce_1m = 1'b1;
    tick();
    we = 1'b0; ce_1m = 1'b0;
    check("wce_reg", 32'(regs[24*8 +: 8]), 32'h9C);
    check("wce_req", 32'(tbl_req), 32'd1);
    repeat (30) tick();

    // Latch decay: still held after 1999 ticks, cleared on the 2000th
    wr(2'b01, 5'h03, 8'hAB);
    cs = 2'b01; addr = 5'h03; #1;
    check("dec_start", 32'(data_out), 32'hAB);
    for (int i = 0; i < 1999; i++) begin
      ce_1m = 1'b1; tick(); ce_1m = 1'b0;
      repeat (3) tick();
    end
    check("dec_1999", 32'(data_out), 32'hAB);
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    tick();
    check("dec_2000", 32'(data_out), 32'h00);

    // Asynchronous reset in the middle of a table pass
    repeat (40) tick();
    ce_1m = 1'b1; tick(); ce_1m = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(tbl_req), 32'd0);
    check("mid_rst_rsp", 32'(tbl_rsp_valid), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_regs", 32'(regs == 400'd0), 32'd1);
    check("mid_rst_audio", 32'(audio_chip == 36'd0), 32'd1);
    repeat (2) tick();
    check("mid_rst_hold", 32'(tbl_req | filt_start), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
